// File: rtl/store_result_monitor.sv
// Hardware self-check on the M-stage store stream: sticky PASS/FAIL/TIMEOUT verdict with counters and failure capture.
// Optional STORE_RESULT_TRACE_EN adds a 4-entry trace of recent in-window stores.
module store_result_monitor #(
    parameter logic [31:0] RESULT_ADDR    = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter logic [31:0] IGNORE_ADDR    = 32'd96,
    parameter logic [31:0] WINDOW_LO      = 32'd90,
    parameter logic [31:0] WINDOW_HI      = 32'd120,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      write_data_m_i,
    input  logic [31:0]      alu_result_m_i,
    input  logic             mem_write_m_i,
    input  logic             clear_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] store_count_o,
    output logic [31:0]      fail_addr_o,
    output logic [31:0]      fail_data_o
`ifdef STORE_RESULT_TRACE_EN
    ,
    input  logic [1:0]       trace_idx_i,
    output logic [31:0]      trace_addr_o,
    output logic [31:0]      trace_data_o,
    output logic             trace_valid_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] store_q, store_d;
    logic [31:0]      fail_addr_q, fail_addr_d;
    logic [31:0]      fail_data_q, fail_data_d;

    logic in_window;
    logic is_pass_store;
    logic is_ignored;

    assign in_window     = mem_write_m_i
                        && (alu_result_m_i > WINDOW_LO)
                        && (alu_result_m_i < WINDOW_HI);
    assign is_pass_store = in_window && (alu_result_m_i == RESULT_ADDR)
                        && (write_data_m_i == PASS_DATA);
    assign is_ignored    = in_window && (alu_result_m_i == IGNORE_ADDR);

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        store_d     = store_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        if (clear_i) begin
            state_d     = ST_RUN;
            cycle_d     = '0;
            store_d     = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (state_q == ST_RUN) begin
            if (cycle_q != '1)
                cycle_d = cycle_q + 1'b1;
            if (mem_write_m_i && (store_q != '1))
                store_d = store_q + 1'b1;

            // A decisive store outranks the timeout on the same edge.
            if (is_pass_store) begin
                state_d = ST_PASS;
            end else if (in_window && !is_ignored) begin
                state_d     = ST_FAIL;
                fail_addr_d = alu_result_m_i;
                fail_data_d = write_data_m_i;
            end else if (cycle_q == TIMEOUT_LAST) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_RUN;
            cycle_q     <= '0;
            store_q     <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            store_q     <= store_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign done_o        = (state_q != ST_RUN);
    assign pass_o        = (state_q == ST_PASS);
    assign fail_o        = (state_q == ST_FAIL);
    assign timeout_o     = (state_q == ST_TIMEOUT);
    assign cycle_count_o = cycle_q;
    assign store_count_o = store_q;
    assign fail_addr_o   = fail_addr_q;
    assign fail_data_o   = fail_data_q;

`ifdef STORE_RESULT_TRACE_EN
    logic [31:0] trace_addr_q [4];
    logic [31:0] trace_data_q [4];
    logic [3:0]  trace_vld_q;
    logic [1:0]  trace_wr_q;
    logic [1:0]  trace_rd;
    logic        trace_we;

    assign trace_we = !clear_i && (state_q == ST_RUN) && in_window;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                trace_addr_q[i] <= '0;
                trace_data_q[i] <= '0;
            end
            trace_vld_q <= '0;
            trace_wr_q  <= '0;
        end else if (clear_i) begin
            trace_vld_q <= '0;
            trace_wr_q  <= '0;
        end else if (trace_we) begin
            trace_addr_q[trace_wr_q] <= alu_result_m_i;
            trace_data_q[trace_wr_q] <= write_data_m_i;
            trace_vld_q[trace_wr_q]  <= 1'b1;
            trace_wr_q               <= trace_wr_q + 2'd1;
        end
    end

    // Index 0 is the most recent write, one slot behind the write pointer.
    assign trace_rd      = trace_wr_q - 2'd1 - trace_idx_i;
    assign trace_addr_o  = trace_addr_q[trace_rd];
    assign trace_data_o  = trace_data_q[trace_rd];
    assign trace_valid_o = trace_vld_q[trace_rd];
`endif

endmodule

// File: tb/tb_store_result_monitor.sv
// Self-checking bench for store_result_monitor: vector table, directed corner sequences and randomized traffic vs a reference model.
module tb_store_result_monitor;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] write_data_m_i = '0;
    logic [31:0] alu_result_m_i = '0;
    logic        mem_write_m_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        done_o, pass_o, fail_o, timeout_o;
    logic [31:0] cycle_count_o, store_count_o, fail_addr_o, fail_data_o;
`ifdef STORE_RESULT_TRACE_EN
    logic [1:0]  trace_idx_i = '0;
    logic [31:0] trace_addr_o, trace_data_o;
    logic        trace_valid_o;
`endif

    store_result_monitor #(
        .RESULT_ADDR(32'd100), .PASS_DATA(32'd25), .IGNORE_ADDR(32'd96),
        .WINDOW_LO(32'd90), .WINDOW_HI(32'd120), .TIMEOUT_CYCLES(10000), .CNT_W(32)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .write_data_m_i(write_data_m_i), .alu_result_m_i(alu_result_m_i),
        .mem_write_m_i(mem_write_m_i), .clear_i(clear_i),
        .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
        .cycle_count_o(cycle_count_o), .store_count_o(store_count_o),
        .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o)
`ifdef STORE_RESULT_TRACE_EN
        , .trace_idx_i(trace_idx_i), .trace_addr_o(trace_addr_o),
        .trace_data_o(trace_data_o), .trace_valid_o(trace_valid_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: verdict as a plain enum, counters as wide integers clipped at 2^32-1.
    typedef enum {M_RUN, M_PASS, M_FAIL, M_TIMEOUT} mstate_t;
    mstate_t     m_state;
    longint      m_cc, m_sc;
    logic [31:0] m_fa, m_fd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state = M_RUN; m_cc = 0; m_sc = 0; m_fa = '0; m_fd = '0;
    endtask

    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic clr);
        bit inwin;
        if (clr) begin
            model_reset();
        end else if (m_state == M_RUN) begin
            inwin = we && (a > 90) && (a < 120);
            if (we && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (inwin && a == 100 && d == 25) m_state = M_PASS;
            else if (inwin && a != 96) begin
                m_state = M_FAIL; m_fa = a; m_fd = d;
            end else if (m_cc == 10000 - 1) m_state = M_TIMEOUT;
            if (m_cc < 64'hFFFF_FFFF) m_cc++;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".done"},    64'(done_o),        64'(m_state != M_RUN));
        check({tag, ".pass"},    64'(pass_o),        64'(m_state == M_PASS));
        check({tag, ".fail"},    64'(fail_o),        64'(m_state == M_FAIL));
        check({tag, ".timeout"}, 64'(timeout_o),     64'(m_state == M_TIMEOUT));
        check({tag, ".cycles"},  64'(cycle_count_o), 64'(m_cc));
        check({tag, ".stores"},  64'(store_count_o), 64'(m_sc));
        check({tag, ".faddr"},   64'(fail_addr_o),   64'(m_fa));
        check({tag, ".fdata"},   64'(fail_data_o),   64'(m_fd));
    endtask

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic clr, input bit chk, input string tag);
        mem_write_m_i = we; alu_result_m_i = a; write_data_m_i = d; clear_i = clr;
        @(posedge clk_i);
        model_step(we, a, d, clr);
        #1;
        mem_write_m_i = 1'b0; alu_result_m_i = '0; write_data_m_i = '0; clear_i = 1'b0;
        if (chk) check_model(tag);
    endtask

    task automatic apply_reset();
        reset_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_model("reset");
        reset_i = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        clr;
        logic [3:0]  exp_flags;  // {done, pass, fail, timeout}
        logic [31:0] exp_stores;
        logic [31:0] exp_faddr;
        logic [31:0] exp_fdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        apply_reset();

        // Basic pass: one store to the result address.
        cycle(1'b1, 32'd100, 32'd25, 1'b0, 1'b1, "pass1");
        check("pass1.flags", 64'({done_o, pass_o, fail_o, timeout_o}), 64'(4'b1100));
        check("pass1.stores", 64'(store_count_o), 64'd1);

        vecs = '{
            '{1'b0, 32'd0,   32'd0,  1'b1, 4'b0000, 32'd0, 32'd0,   32'd0},
            '{1'b1, 32'd96,  32'd7,  1'b0, 4'b0000, 32'd1, 32'd0,   32'd0},
            '{1'b1, 32'd90,  32'd0,  1'b0, 4'b0000, 32'd2, 32'd0,   32'd0},
            '{1'b1, 32'd120, 32'd0,  1'b0, 4'b0000, 32'd3, 32'd0,   32'd0},
            '{1'b1, 32'd200, 32'd5,  1'b0, 4'b0000, 32'd4, 32'd0,   32'd0},
            '{1'b1, 32'd100, 32'd24, 1'b0, 4'b1010, 32'd5, 32'd100, 32'd24},
            '{1'b1, 32'd100, 32'd25, 1'b0, 4'b1010, 32'd5, 32'd100, 32'd24},
            '{1'b0, 32'd0,   32'd0,  1'b1, 4'b0000, 32'd0, 32'd0,   32'd0},
            '{1'b1, 32'd96,  32'd7,  1'b0, 4'b0000, 32'd1, 32'd0,   32'd0},
            '{1'b1, 32'd100, 32'd25, 1'b0, 4'b1100, 32'd2, 32'd0,   32'd0},
            '{1'b1, 32'd104, 32'd3,  1'b1, 4'b0000, 32'd0, 32'd0,   32'd0},
            '{1'b1, 32'd104, 32'd3,  1'b0, 4'b1010, 32'd1, 32'd104, 32'd3},
            '{1'b1, 32'd100, 32'd25, 1'b0, 4'b1010, 32'd1, 32'd104, 32'd3},
            '{1'b0, 32'd0,   32'd0,  1'b1, 4'b0000, 32'd0, 32'd0,   32'd0},
            '{1'b1, 32'h8000_0064, 32'd9, 1'b0, 4'b0000, 32'd1, 32'd0, 32'd0},
            '{1'b1, 32'd119, 32'd1,  1'b0, 4'b1010, 32'd2, 32'd119, 32'd1},
            '{1'b0, 32'd0,   32'd0,  1'b1, 4'b0000, 32'd0, 32'd0,   32'd0},
            '{1'b1, 32'd91,  32'd1,  1'b0, 4'b1010, 32'd1, 32'd91,  32'd1}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].clr, 1'b0, "vec");
            check($sformatf("vec%0d.flags", i), 64'({done_o, pass_o, fail_o, timeout_o}), 64'(vecs[i].exp_flags));
            check($sformatf("vec%0d.stores", i), 64'(store_count_o), 64'(vecs[i].exp_stores));
            check($sformatf("vec%0d.faddr", i), 64'(fail_addr_o), 64'(vecs[i].exp_faddr));
            check($sformatf("vec%0d.fdata", i), 64'(fail_data_o), 64'(vecs[i].exp_fdata));
        end

        // Timeout with no decisive store.
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, "to.clr");
        for (int i = 0; i < 9999; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "");
        check("to.pre.timeout", 64'(timeout_o), 64'd0);
        check("to.pre.cycles", 64'(cycle_count_o), 64'd9999);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, "to.edge");
        check("to.timeout", 64'(timeout_o), 64'd1);
        check("to.cycles", 64'(cycle_count_o), 64'd10000);
        cycle(1'b1, 32'd100, 32'd25, 1'b0, 1'b1, "to.sticky");
        check("to.sticky.cycles", 64'(cycle_count_o), 64'd10000);

        // Pass store on the final RUN edge beats the timeout.
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, "race.clr");
        for (int i = 0; i < 9999; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "");
        cycle(1'b1, 32'd100, 32'd25, 1'b0, 1'b1, "race");
        check("race.flags", 64'({done_o, pass_o, fail_o, timeout_o}), 64'(4'b1100));
        check("race.cycles", 64'(cycle_count_o), 64'd10000);

        // Randomized traffic against the model.
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, "rnd.clr");
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic        we, clr;
            logic [31:0] a, d;
            r = $urandom_range(0, 99);
            we = 1'b1; a = $urandom; d = $urandom_range(0, 40);
            if (r < 45) we = 1'b0;
            else if (r < 75) a = $urandom;
            else if (r < 90) a = 32'd96;
            else if (r < 94) begin a = 32'd100; d = 32'd25; end
            else a = 32'($urandom_range(88, 122));
            clr = ($urandom_range(0, 99) < 3);
            cycle(we, a, d, clr, 1'b1, "rnd");
        end

        // Asynchronous reset mid-run, observed before any clock edge.
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "");
        cycle(1'b1, 32'd96, 32'd1, 1'b0, 1'b0, "");
        cycle(1'b1, 32'd104, 32'd2, 1'b0, 1'b1, "pre_arst");
        #2;
        reset_i = 1'b0;
        model_reset();
        #1;
        check_model("arst");
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        cycle(1'b1, 32'd100, 32'd25, 1'b0, 1'b1, "post_arst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_result_monitor.md
Name: store_result_monitor

Overview:
- Synthesizable consumer of the memory-stage store stream (write_data_m, alu_result_m, mem_write_m) at the riscv_top boundary.
- Watches stores in a result address window and decides PASS, FAIL or TIMEOUT in hardware.
- Lets FPGA builds and benches share one self-check with sticky status, cycle/store counters and failure capture.

Parameters:
- RESULT_ADDR, 100: address whose store carries the test verdict.
- PASS_DATA, 25: data value at RESULT_ADDR that means pass.
- IGNORE_ADDR, 96: in-window address that is always ignored (scratch store).
- WINDOW_LO, 90: window lower bound, exclusive.
- WINDOW_HI, 120: window upper bound, exclusive.
- TIMEOUT_CYCLES, 10000: RUN cycles before TIMEOUT.
- CNT_W, 32: width of cycle and store counters.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- write_data_m_i  input  32  store data from the M stage.
- alu_result_m_i  input  32  store address from the M stage.
- mem_write_m_i  input  1  store valid from the M stage.
- clear_i  input  1  synchronous restart: back to RUN, counters and captures zeroed.
- done_o  output  1  high in PASS, FAIL or TIMEOUT.
- pass_o  output  1  high only in PASS.
- fail_o  output  1  high only in FAIL.
- timeout_o  output  1  high only in TIMEOUT.
- cycle_count_o  output  CNT_W  cycles spent in RUN, saturating.
- store_count_o  output  CNT_W  mem_write_m_i cycles seen in RUN, saturating.
- fail_addr_o  output  32  address of the offending store; 0 unless FAIL.
- fail_data_o  output  32  data of the offending store; 0 unless FAIL.

Behaviour:
- Reset (reset_i low, async): state=RUN; all outputs and counters 0.
- Release of reset is synchronous to clk_i.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are sticky until reset or clear_i.
- In-window test: mem_write_m_i=1 and WINDOW_LO < alu_result_m_i < WINDOW_HI, unsigned 32-bit compare.
- Transitions from RUN, decided on the edge where the store is sampled:
  - In-window store, addr==RESULT_ADDR, data==PASS_DATA -> PASS.
  - In-window store, addr==IGNORE_ADDR -> stay RUN.
  - Any other in-window store, including RESULT_ADDR with wrong data -> FAIL; capture addr/data into fail_addr_o/fail_data_o.
  - Out-of-window stores are ignored except for store_count.
- Status outputs are registered: 1 cycle latency from the sampled store edge.
- cycle_count increments every RUN cycle and saturates at all-ones.
- TIMEOUT taken when, in RUN, cycle_count == TIMEOUT_CYCLES-1 on the incrementing edge and no decisive store is present.
- Simultaneous decisive store and timeout edge: the store verdict wins.
- store_count increments on every mem_write_m_i cycle in RUN; frozen outside RUN; saturates.
- clear_i has priority over every transition: next state RUN, counters 0, captures 0, status low.
- Reset mid-run: immediate return to reset values regardless of clk_i.
- X on inputs is not handled; bench must drive known values after reset.

Optional Feature:
- Macro: STORE_RESULT_TRACE_EN.
- When defined:
  - Adds a 4-entry circular trace of the last in-window stores (addr, data) taken in RUN, including ignored ones.
  - Write pointer wraps 3->0 and overwrites the oldest entry.
  - Extra ports: trace_idx_i input 2, trace_addr_o output 32, trace_data_o output 32, trace_valid_o output 1.
  - Read is combinational by index; index 0 = most recent.
  - trace_valid_o=0 for entries not yet written since reset/clear.
- When undefined: no trace storage and none of the extra ports exist.

Test Plan:
- Reset low 2 cycles then high; store (addr 100, data 25) -> pass_o=done_o=1 next cycle, fail_o=timeout_o=0, store_count_o=1.
- Store (96, 7) then (100, 25) -> first ignored and state stays RUN; pass_o rises after the second; store_count_o=2.
- Store (104, 3) -> fail_o=1, fail_addr_o=104, fail_data_o=3; a later (100, 25) does not change state.
- Boundary: stores at addr 90 and 120 (data 0) stay RUN; store (100, 24) -> FAIL.
- Timeout: no in-window stores for 10000 cycles -> timeout_o=1, cycle_count_o=10000; a store (100, 25) on the final RUN edge gives PASS instead.
- Assert clear_i after FAIL, then store (100, 25) -> counters restart from 0, pass_o=1.
- Assert reset_i low asynchronously mid-run -> all outputs 0 without waiting for a clock edge.
